// File: rtl/csr_issue_ctrl.sv
// +----------------------------------------------------------------------------+
// | csr_issue_ctrl : holds one CSR uop until it is the ROB head, fires it once  |
// | into execute_csr and returns the old CSR value on a valid/ready port.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package config_pkg;
    typedef struct packed {
        logic [31:0] XLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{XLEN: 32'd32};
endpackage

package decode_pkg;
    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_e;

    typedef struct packed {
        logic        is_csr;
        csr_op_e     csr_op;
        logic [11:0] csr_addr;
        logic [31:0] imm;
    } uop_t;
endpackage

module csr_issue_ctrl #(
    parameter config_pkg::cfg_t Cfg   = config_pkg::EmptyCfg,
    parameter int unsigned      TAG_W = 6,
    parameter int unsigned      XLEN  = Cfg.XLEN
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  decode_pkg::uop_t    req_uop_i,
    input  logic [XLEN-1:0]     req_rs1_data_i,
    input  logic [TAG_W-1:0]    req_rob_tag_i,
    input  logic                rob_head_valid_i,
    input  logic [TAG_W-1:0]    rob_head_tag_i,
    input  logic                flush_i,
    output logic                csr_valid_o,
    output decode_pkg::uop_t    csr_uop_o,
    output logic [XLEN-1:0]     csr_rs1_data_o,
    output logic [TAG_W-1:0]    csr_rob_tag_o,
    input  logic                csr_valid_i,
    input  logic [TAG_W-1:0]    csr_rob_tag_i,
    input  logic [XLEN-1:0]     csr_result_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [TAG_W-1:0]    wb_rob_tag_o,
    output logic [XLEN-1:0]     wb_result_o,
    output logic                busy_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HEAD = 2'd1,
        WB        = 2'd2
    } state_e;

    state_e             state_q, state_d;
    decode_pkg::uop_t   uop_q;
    logic [XLEN-1:0]    rs1_q;
    logic [TAG_W-1:0]   tag_q;
    logic [XLEN-1:0]    wb_result_q;
    logic [TAG_W-1:0]   wb_tag_q;
    logic               err_q, err_d;
    logic               accept;
    logic               fire;

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        accept      = 1'b0;
        fire        = 1'b0;
        req_ready_o = 1'b0;
        wb_valid_o  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i && !flush_i) begin
                    accept  = 1'b1;
                    state_d = WAIT_HEAD;
                end
            end
            WAIT_HEAD: begin
                // Firing only at the ROB head keeps CSR side effects non-speculative.
                fire = rob_head_valid_i && (rob_head_tag_i == tag_q) && !flush_i;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (fire) begin
                    state_d = WB;
                    if (!csr_valid_i || (csr_rob_tag_i != tag_q)) begin
                        err_d = 1'b1;
                    end
                end
            end
            WB: begin
                wb_valid_o = 1'b1;
                if (flush_i || wb_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            uop_q       <= '0;
            rs1_q       <= '0;
            tag_q       <= '0;
            wb_result_q <= '0;
            wb_tag_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (accept) begin
                uop_q <= req_uop_i;
                rs1_q <= req_rs1_data_i;
                tag_q <= req_rob_tag_i;
            end
            if (fire) begin
                wb_result_q <= csr_result_i;
                wb_tag_q    <= tag_q;
            end
        end
    end

    assign csr_valid_o    = fire;
    assign csr_uop_o      = uop_q;
    assign csr_rs1_data_o = rs1_q;
    assign csr_rob_tag_o  = tag_q;
    assign wb_rob_tag_o   = wb_tag_q;
    assign wb_result_o    = wb_result_q;
    assign busy_o         = (state_q != IDLE);
    assign err_o          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_csr_issue_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_csr_issue_ctrl : vector table plus directed flush/reset sequences, with  |
// | a small CSR file standing in for execute_csr. Revision: 1.0                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_csr_issue_ctrl;
    import decode_pkg::*;

    localparam int TAG_W = 6;
    localparam int XLEN  = 32;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             req_valid_i;
    logic             req_ready_o;
    uop_t             req_uop_i;
    logic [XLEN-1:0]  req_rs1_data_i;
    logic [TAG_W-1:0] req_rob_tag_i;
    logic             rob_head_valid_i;
    logic [TAG_W-1:0] rob_head_tag_i;
    logic             flush_i;
    logic             csr_valid_o;
    uop_t             csr_uop_o;
    logic [XLEN-1:0]  csr_rs1_data_o;
    logic [TAG_W-1:0] csr_rob_tag_o;
    logic             csr_valid_i;
    logic [TAG_W-1:0] csr_rob_tag_i;
    logic [XLEN-1:0]  csr_result_i;
    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [TAG_W-1:0] wb_rob_tag_o;
    logic [XLEN-1:0]  wb_result_o;
    logic             busy_o;
    logic             err_o;

    always #5 clk = ~clk;

    csr_issue_ctrl #(.TAG_W(TAG_W)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_uop_i        (req_uop_i),
        .req_rs1_data_i   (req_rs1_data_i),
        .req_rob_tag_i    (req_rob_tag_i),
        .rob_head_valid_i (rob_head_valid_i),
        .rob_head_tag_i   (rob_head_tag_i),
        .flush_i          (flush_i),
        .csr_valid_o      (csr_valid_o),
        .csr_uop_o        (csr_uop_o),
        .csr_rs1_data_o   (csr_rs1_data_o),
        .csr_rob_tag_o    (csr_rob_tag_o),
        .csr_valid_i      (csr_valid_i),
        .csr_rob_tag_i    (csr_rob_tag_i),
        .csr_result_i     (csr_result_i),
        .wb_valid_o       (wb_valid_o),
        .wb_ready_i       (wb_ready_i),
        .wb_rob_tag_o     (wb_rob_tag_o),
        .wb_result_o      (wb_result_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    // Stand-in for execute_csr: returns the old value, writes on the fire edge.
    logic [31:0] r_mtvec    = 32'h0;
    logic [31:0] r_mstatus  = 32'h1800;
    logic [31:0] r_mscratch = 32'h0;
    logic [31:0] w_old, w_new;

    always_comb begin
        w_old = 32'h0;
        case (csr_uop_o.csr_addr)
            12'h305: w_old = r_mtvec;
            12'h300: w_old = r_mstatus;
            12'h340: w_old = r_mscratch;
            default: w_old = 32'h0;
        endcase
        case (csr_uop_o.csr_op)
            CSR_RW:  w_new = csr_rs1_data_o;
            CSR_RS:  w_new = w_old | csr_rs1_data_o;
            CSR_RC:  w_new = w_old & ~csr_rs1_data_o;
            default: w_new = w_old;
        endcase
        csr_valid_i   = 1'b0;
        csr_rob_tag_i = '0;
        csr_result_i  = '0;
        if (csr_valid_o && csr_uop_o.is_csr) begin
            csr_valid_i   = 1'b1;
            csr_rob_tag_i = csr_rob_tag_o;
            csr_result_i  = w_old;
        end
    end

    always @(posedge clk) begin
        if (csr_valid_o && csr_uop_o.is_csr) begin
            case (csr_uop_o.csr_addr)
                12'h305: r_mtvec    <= w_new;
                12'h300: r_mstatus  <= w_new;
                12'h340: r_mscratch <= w_new;
                default: ;
            endcase
        end
    end

    int errors = 0;
    int checks = 0;
    int fires  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  res;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (rst_ni && csr_valid_o) fires++;
        if (rst_ni && wb_valid_o && wb_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got tag 0x%0h with no queued expectation", wb_rob_tag_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_tag", 64'(wb_rob_tag_o), 64'(e.tag));
                chk("wb_result", 64'(wb_result_o), 64'(e.res));
            end
        end
    end

    typedef struct {
        csr_op_e          op;
        logic [11:0]      addr;
        logic [31:0]      rs1;
        logic [TAG_W-1:0] tag;
        logic             is_csr;
        int               hwait;
        int               stall;
        logic [31:0]      exp_res;
        logic             exp_err;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(csr_op_e op, logic [11:0] addr, logic [31:0] rs1,
                                logic [TAG_W-1:0] tag, logic is_csr, int hwait,
                                int stall, logic [31:0] exp_res, logic exp_err);
        vec_t v;
        v.op = op; v.addr = addr; v.rs1 = rs1; v.tag = tag; v.is_csr = is_csr;
        v.hwait = hwait; v.stall = stall; v.exp_res = exp_res; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input csr_op_e op, input logic [11:0] addr,
                             input logic [31:0] rs1, input logic [TAG_W-1:0] tag,
                             input logic is_csr);
        req_valid_i             = 1'b1;
        req_uop_i.is_csr        = is_csr;
        req_uop_i.csr_op        = op;
        req_uop_i.csr_addr      = addr;
        req_uop_i.imm           = 32'h0;
        req_rs1_data_i          = rs1;
        req_rob_tag_i           = tag;
    endtask

    task automatic run_uop(input vec_t v);
        int f0;
        chk("ready_idle", 64'(req_ready_o), 64'd1);
        drive_req(v.op, v.addr, v.rs1, v.tag, v.is_csr);
        rob_head_valid_i = 1'b1;
        rob_head_tag_i   = (v.hwait == 0) ? v.tag : v.tag + 1'b1;
        f0 = fires;
        sb.push_back('{v.tag, v.exp_res});
        step();
        req_valid_i    = 1'b0;
        req_rs1_data_i = 32'hDEAD_BEEF;
        req_rob_tag_i  = ~v.tag;
        #1;
        chk("busy_after_accept", 64'(busy_o), 64'd1);
        chk("held_tag", 64'(csr_rob_tag_o), 64'(v.tag));
        chk("held_rs1", 64'(csr_rs1_data_o), 64'(v.rs1));
        for (int i = 0; i < v.hwait; i++) begin
            chk("no_fire_wait", 64'(csr_valid_o), 64'd0);
            chk("ready_low_wait", 64'(req_ready_o), 64'd0);
            step();
        end
        rob_head_tag_i = v.tag;
        #1;
        chk("fire", 64'(csr_valid_o), 64'd1);
        step();
        rob_head_valid_i = 1'b0;
        for (int i = 0; i < v.stall; i++) begin
            #1;
            chk("wb_valid_stall", 64'(wb_valid_o), 64'd1);
            chk("wb_tag_stable", 64'(wb_rob_tag_o), 64'(v.tag));
            chk("wb_res_stable", 64'(wb_result_o), 64'(v.exp_res));
            step();
        end
        wb_ready_i = 1'b1;
        #1;
        chk("wb_valid", 64'(wb_valid_o), 64'd1);
        step();
        wb_ready_i = 1'b0;
        #1;
        chk("idle_after_wb", 64'(busy_o), 64'd0);
        chk("ready_after_wb", 64'(req_ready_o), 64'd1);
        chk("one_pulse", 64'(fires - f0), 64'd1);
        chk("err_flag", 64'(err_o), 64'(v.exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        vecs[0] = mk(CSR_RW, 12'h305, 32'h8000_0100, 6'd5,  1'b1, 0, 0, 32'h0,          1'b0);
        vecs[1] = mk(CSR_RS, 12'h305, 32'h0,         6'd6,  1'b1, 0, 0, 32'h8000_0100,  1'b0);
        vecs[2] = mk(CSR_RW, 12'h340, 32'h1234_5678, 6'd9,  1'b1, 4, 0, 32'h0,          1'b0);
        vecs[3] = mk(CSR_RS, 12'h340, 32'h0,         6'd10, 1'b1, 0, 3, 32'h1234_5678,  1'b0);
        vecs[4] = mk(CSR_RC, 12'h340, 32'h0000_00FF, 6'd63, 1'b1, 1, 0, 32'h1234_5678,  1'b0);
        vecs[5] = mk(CSR_RS, 12'h340, 32'h0,         6'd0,  1'b1, 2, 1, 32'h1234_5600,  1'b0);
        vecs[6] = mk(CSR_RS, 12'h300, 32'h0,         6'd30, 1'b1, 0, 0, 32'h0000_1800,  1'b0);
        vecs[7] = mk(CSR_RS, 12'h340, 32'h0,         6'd31, 1'b1, 0, 0, 32'hA5A5_A5A5,  1'b0);
        vecs[8] = mk(CSR_RW, 12'h305, 32'h0,         6'd40, 1'b0, 0, 2, 32'h0,          1'b1);
        vecs[9] = mk(CSR_RS, 12'h305, 32'h0,         6'd41, 1'b1, 1, 0, 32'h8000_0100,  1'b1);

        rst_ni = 1'b0; req_valid_i = 1'b0; req_uop_i = '0; req_rs1_data_i = '0;
        req_rob_tag_i = '0; rob_head_valid_i = 1'b0; rob_head_tag_i = '0;
        flush_i = 1'b0; wb_ready_i = 1'b0;
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'd1);
        chk("rst_csr_valid", 64'(csr_valid_o), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_wb_tag", 64'(wb_rob_tag_o), 64'd0);
        chk("rst_wb_res", 64'(wb_result_o), 64'd0);
        chk("rst_hold_tag", 64'(csr_rob_tag_o), 64'd0);
        chk("rst_hold_rs1", 64'(csr_rs1_data_o), 64'd0);
        chk("rst_hold_uop", 64'(csr_uop_o), 64'd0);
        step(); step();
        rst_ni = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_uop(vecs[i]);

        // Flush while waiting for the head: no fire, back to IDLE.
        drive_req(CSR_RS, 12'h300, 32'h8, 6'd12, 1'b1);
        rob_head_valid_i = 1'b1; rob_head_tag_i = 6'd7;
        f0 = fires;
        step();
        req_valid_i = 1'b0;
        step();
        flush_i = 1'b1;
        #1 chk("flush_wait_no_fire", 64'(csr_valid_o), 64'd0);
        step();
        flush_i = 1'b0;
        #1 chk("flush_wait_idle", 64'(busy_o), 64'd0);

        // Flush in the same cycle the head matches.
        drive_req(CSR_RW, 12'h300, 32'hFFFF, 6'd13, 1'b1);
        rob_head_tag_i = 6'd13;
        step();
        req_valid_i = 1'b0;
        flush_i = 1'b1;
        #1 chk("flush_match_no_fire", 64'(csr_valid_o), 64'd0);
        step();
        flush_i = 1'b0;
        #1 chk("flush_match_idle", 64'(busy_o), 64'd0);
        chk("flush_no_pulses", 64'(fires - f0), 64'd0);

        // Flush in IDLE blocks acceptance.
        drive_req(CSR_RW, 12'h300, 32'hFFFF, 6'd15, 1'b1);
        flush_i = 1'b1;
        step();
        req_valid_i = 1'b0; flush_i = 1'b0;
        #1 chk("flush_idle_no_accept", 64'(busy_o), 64'd0);

        // Matching tag but head entry not valid: no fire until it becomes valid.
        drive_req(CSR_RS, 12'h340, 32'h0, 6'd14, 1'b1);
        rob_head_valid_i = 1'b0; rob_head_tag_i = 6'd14;
        sb.push_back('{6'd14, 32'h1234_5600});
        step();
        req_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("head_invalid_no_fire", 64'(csr_valid_o), 64'd0);
            step();
        end
        rob_head_valid_i = 1'b1;
        #1 chk("head_valid_fire", 64'(csr_valid_o), 64'd1);
        step();
        rob_head_valid_i = 1'b0; wb_ready_i = 1'b1;
        step();
        wb_ready_i = 1'b0;

        // Flush in WB drops the writeback but the CSR write already happened.
        drive_req(CSR_RW, 12'h340, 32'hA5A5_A5A5, 6'd20, 1'b1);
        rob_head_valid_i = 1'b1; rob_head_tag_i = 6'd20;
        step();
        req_valid_i = 1'b0;
        #1 chk("wbflush_fire", 64'(csr_valid_o), 64'd1);
        step();
        rob_head_valid_i = 1'b0;
        #1 chk("wbflush_in_wb", 64'(wb_valid_o), 64'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1 chk("wbflush_idle", 64'(busy_o), 64'd0);
        chk("wbflush_wb_dropped", 64'(wb_valid_o), 64'd0);

        // Asynchronous reset in WAIT_HEAD with the head matching: no fire.
        drive_req(CSR_RW, 12'h305, 32'h1, 6'd50, 1'b1);
        rob_head_valid_i = 1'b1; rob_head_tag_i = 6'd51;
        step();
        req_valid_i = 1'b0;
        step();
        rob_head_tag_i = 6'd50;
        rst_ni = 1'b0;
        #1;
        chk("arst_no_fire", 64'(csr_valid_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_ready", 64'(req_ready_o), 64'd1);
        chk("arst_hold_tag", 64'(csr_rob_tag_o), 64'd0);
        step();
        rob_head_valid_i = 1'b0;
        rst_ni = 1'b1;
        step();

        for (int i = 6; i < 10; i++) run_uop(vecs[i]);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
